register_file_mp: RTL and testbench

//   Parametrised multi-port general-purpose register file with integrated scoreboard.
//   - Replaces the single-read-pair/single-write GPR bench in the core.
//   - Sits between decode (read/reserve) and writeback (write/release).
//   - Adds N read ports, M write ports, optional write-to-read bypass and per-register

---
 rtl/register_file_mp_if.sv | 36 +++
 rtl/register_file_mp.sv | 111 +++++++++++
 tb/tb_register_file_mp.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: bus bundle for the multi-port register file.
//   rd_addr_i / rd_data_o / rd_busy_o : NRD read ports (packed, port k at k*width)
//   wr_en_i / wr_addr_i / wr_data_i   : NWR write ports (packed)
//   rsv_en_i / rsv_addr_i             : destination reservation from issue
//   busy_o                            : registered scoreboard vector
//   wr_collide_o                      : registered same-register write conflict pulse
// slave modport is the register file; master modport is decode/writeback.
interface register_file_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wr_en_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                rsv_en_i;
  logic [AW-1:0]       rsv_addr_i;
  logic [NREGS-1:0]    busy_o;
  logic                wr_collide_o;

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
    output rd_data_o, rd_busy_o, busy_o, wr_collide_o
  );

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
    input  rd_data_o, rd_busy_o, busy_o, wr_collide_o
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port GPR file with integrated busy scoreboard.
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset
//   bus  : register_file_mp_if slave (read ports, write ports, reserve,
//          busy vector, write-collision pulse)
// Register 0 is hardwired to zero, never busy, and ignored by writes/reserves.
// Reads are combinational; with BYPASS=1 an enabled write to the read
// address in the same cycle is forwarded (highest write port wins).
module register_file_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       collide_q, collide_d;

  // Per-register write resolution for this cycle
  logic [NREGS-1:0]           wr_hit;
  logic [NREGS-1:0][XLEN-1:0] wr_val;

  logic [NRD*XLEN-1:0]        rd_data;
  logic [NRD-1:0]             rd_busy;

  // Ascending port order: a later port overwrites an earlier one, so the
  // highest-indexed port wins on a shared address.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (bus.wr_en_i[w] && (bus.wr_addr_i[w*AW +: AW] != '0)) begin
        wr_hit[bus.wr_addr_i[w*AW +: AW]] = 1'b1;
        wr_val[bus.wr_addr_i[w*AW +: AW]] = bus.wr_data_i[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    collide_d = 1'b0;
    for (int unsigned i = 0; i < NWR; i++) begin
      for (int unsigned j = i + 1; j < NWR; j++) begin
        if (bus.wr_en_i[i] && bus.wr_en_i[j] &&
            (bus.wr_addr_i[i*AW +: AW] == bus.wr_addr_i[j*AW +: AW]) &&
            (bus.wr_addr_i[i*AW +: AW] != '0)) begin
          collide_d = 1'b1;
        end
      end
    end
  end

  // Reserve is applied after writes so a same-cycle reserve keeps the
  // register busy while the write data is still committed.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (wr_hit[r]) begin
        regs_d[r] = wr_val[r];
        busy_d[r] = 1'b0;
      end
    end
    if (bus.rsv_en_i && (bus.rsv_addr_i != '0)) begin
      busy_d[bus.rsv_addr_i] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '0;
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  // Bypass must also be masked during reset, since stored state is already
  // zero but incoming write data would otherwise reach the read ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NRD; k++) begin
        if ((BYPASS != 0) && wr_hit[bus.rd_addr_i[k*AW +: AW]]) begin
          rd_data[k*XLEN +: XLEN] = wr_val[bus.rd_addr_i[k*AW +: AW]];
          rd_busy[k]              = 1'b0;
        end else begin
          rd_data[k*XLEN +: XLEN] = regs_q[bus.rd_addr_i[k*AW +: AW]];
          rd_busy[k]              = busy_q[bus.rd_addr_i[k*AW +: AW]];
        end
      end
    end
  end

  assign bus.rd_data_o    = rd_data;
  assign bus.rd_busy_o    = rd_busy;
  assign bus.busy_o       = busy_q;
  assign bus.wr_collide_o = collide_q;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: drives a BYPASS=1 and a BYPASS=0 instance with
// identical stimulus; expected values are queued when inputs are driven and
// compared at the following negedge.
module tb_register_file_mp;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ifb ();
  register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ifn ();

  register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (ifn.slave)
  );

  // Shared stimulus
  logic [4:0]  ra [2];
  logic        we [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        rv;
  logic [4:0]  rva;

  assign ifb.rd_addr_i  = {ra[1], ra[0]};
  assign ifb.wr_en_i    = {we[1], we[0]};
  assign ifb.wr_addr_i  = {wa[1], wa[0]};
  assign ifb.wr_data_i  = {wd[1], wd[0]};
  assign ifb.rsv_en_i   = rv;
  assign ifb.rsv_addr_i = rva;
  assign ifn.rd_addr_i  = {ra[1], ra[0]};
  assign ifn.wr_en_i    = {we[1], we[0]};
  assign ifn.wr_addr_i  = {wa[1], wa[0]};
  assign ifn.wr_data_i  = {wd[1], wd[0]};
  assign ifn.rsv_en_i   = rv;
  assign ifn.rsv_addr_i = rva;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_coll;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q [$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  string sel_name [12] = '{"rd_data0_b", "rd_data1_b", "rd_busy0_b", "rd_busy1_b",
                           "rd_data0_n", "rd_data1_n", "rd_busy0_n", "rd_busy1_n",
                           "busy_b", "collide_b", "busy_n", "collide_n"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] obs(input int unsigned sel);
    case (sel)
      0:  return ifb.rd_data_o[31:0];
      1:  return ifb.rd_data_o[63:32];
      2:  return {31'b0, ifb.rd_busy_o[0]};
      3:  return {31'b0, ifb.rd_busy_o[1]};
      4:  return ifn.rd_data_o[31:0];
      5:  return ifn.rd_data_o[63:32];
      6:  return {31'b0, ifn.rd_busy_o[0]};
      7:  return {31'b0, ifn.rd_busy_o[1]};
      8:  return ifb.busy_o;
      9:  return {31'b0, ifb.wr_collide_o};
      10: return ifn.busy_o;
      11: return {31'b0, ifn.wr_collide_o};
      default: return 'x;
    endcase
  endfunction

  task automatic expc(input string tag, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    m_coll = 1'b0;
  endtask

  task automatic set_in(input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic rv_, input logic [4:0] rva_);
    ra[0] = ra0; ra[1] = ra1;
    we[0] = we0; wa[0] = wa0; wd[0] = wd0;
    we[1] = we1; wa[1] = wa1; wd[1] = wd1;
    rv = rv_; rva = rva_;
  endtask

  // Apply inputs and queue the model's view of every output for this cycle.
  task automatic drive(input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rv_, input logic [4:0] rva_);
    logic        hit;
    logic [31:0] v;
    set_in(ra0, ra1, we0, wa0, wd0, we1, wa1, wd1, rv_, rva_);
    for (int k = 0; k < 2; k++) begin
      hit = 1'b0;
      v   = '0;
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w] == ra[k] && ra[k] != 5'd0) begin
          hit = 1'b1;
          v   = wd[w];
        end
      end
      expc(sel_name[k],   k,     hit ? v : m_regs[ra[k]]);
      expc(sel_name[2+k], 2 + k, hit ? 32'd0 : {31'b0, m_busy[ra[k]]});
      expc(sel_name[4+k], 4 + k, m_regs[ra[k]]);
      expc(sel_name[6+k], 6 + k, {31'b0, m_busy[ra[k]]});
    end
    expc(sel_name[8],  8,  m_busy);
    expc(sel_name[9],  9,  {31'b0, m_coll});
    expc(sel_name[10], 10, m_busy);
    expc(sel_name[11], 11, {31'b0, m_coll});
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    drive(ra0, ra1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Compare at negedge, then advance the model across the next posedge.
  task automatic tick();
    logic [31:0] n_regs [32];
    logic [31:0] n_busy;
    logic        n_coll;
    @(negedge clk);
    drain();
    n_regs = m_regs;
    n_busy = m_busy;
    n_coll = we[0] && we[1] && (wa[0] == wa[1]) && (wa[0] != 5'd0);
    for (int w = 0; w < 2; w++) begin
      if (we[w] && wa[w] != 5'd0) begin
        n_regs[wa[w]] = wd[w];
        n_busy[wa[w]] = 1'b0;
      end
    end
    if (rv && rva != 5'd0) n_busy[rva] = 1'b1;
    @(posedge clk);
    #1;
    if (rst) begin
      m_reset();
    end else begin
      m_regs = n_regs;
      m_busy = n_busy;
      m_coll = n_coll;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 12; s++) expc({"reset_", sel_name[s]}, s, 32'd0);
    drain();
    rst = 1'b0;

    // Register 0: write and reserve are both ignored
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    expc("zero_byp_rd", 0, 32'd0);
    tick();
    idle(5'd0, 5'd0);
    expc("zero_rd", 0, 32'd0);
    expc("zero_busy", 8, 32'd0);
    expc("zero_coll", 9, 32'd0);
    tick();

    // Bypass versus stored value
    drive(5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_0BAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    drive(5'd0, 5'd3, 1'b1, 5'd3, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    expc("byp_rd1", 1, 32'hA5A5_0001);
    expc("nobyp_rd1", 5, 32'h0000_0BAD);
    tick();
    idle(5'd0, 5'd3);
    expc("nobyp_next", 5, 32'hA5A5_0001);
    tick();

    // Two write ports on the same register
    drive(5'd7, 5'd0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    expc("coll_byp_win", 0, 32'h22);
    expc("coll_same_cycle", 9, 32'd0);
    tick();
    idle(5'd7, 5'd7);
    expc("coll_val", 4, 32'h22);
    expc("coll_pulse", 9, 32'd1);
    expc("coll_pulse_n", 11, 32'd1);
    tick();
    idle(5'd7, 5'd0);
    expc("coll_end", 9, 32'd0);
    tick();

    // Scoreboard reserve then release
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    expc("rsv_same_rdbusy", 2, 32'd0);
    tick();
    idle(5'd9, 5'd9);
    expc("rsv_vec", 8, 32'h0000_0200);
    expc("rsv_rdbusy", 3, 32'd1);
    tick();
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0);
    expc("wr_byp_rdbusy", 3, 32'd0);
    expc("wr_nobyp_rdbusy", 7, 32'd1);
    tick();
    idle(5'd9, 5'd0);
    expc("wr_clear", 8, 32'd0);
    expc("wr_data", 0, 32'h55);
    tick();

    // Reserve and write racing on one register
    drive(5'd4, 5'd0, 1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    tick();
    idle(5'd4, 5'd0);
    expc("race_data", 0, 32'h77);
    expc("race_rdbusy", 2, 32'd1);
    expc("race_vec", 8, 32'h0000_0010);
    tick();

    // Reset mid-operation with a write and reserve in flight
    drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    tick();
    set_in(5'd5, 5'd6, 1'b1, 5'd5, 32'h1111_2222, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
    #1;
    rst = 1'b1;
    #1;
    for (int s = 0; s < 12; s++) expc({"midrst_", sel_name[s]}, s, 32'd0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    idle(5'd5, 5'd6);
    expc("rst_r5", 0, 32'd0);
    expc("rst_busy", 8, 32'd0);
    tick();

    // Randomised traffic over a narrow address range to provoke conflicts
    repeat (300) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
